// File: rtl/rr_mux_8to1.sv
// Round-robin 8:1 stream collector with a registered one-entry output stage.
// Each output word is tagged with the 3-bit index of the lane it came from.
module rr_mux_8to1 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         in_valid,
    input  logic [8*WIDTH-1:0] in_data,
    output logic [7:0]         in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [2:0]         out_sel,
    input  logic               out_ready
);

    logic [2:0]       ptr;
    logic [2:0]       grant;
    logic [2:0]       idx;
    logic             grant_valid;
    logic             can_load;
    logic             xfer;
    logic [WIDTH-1:0] grant_data;

    // First valid lane scanning ptr, ptr+1, ... with 3-bit wraparound.
    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        idx         = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            idx = ptr + 3'(k);
            if (!grant_valid && in_valid[idx]) begin
                grant_valid = 1'b1;
                grant       = idx;
            end
        end
    end

    assign can_load   = !out_valid || out_ready;
    assign xfer       = grant_valid && can_load && !rst;
    assign in_ready   = xfer ? (8'(1) << grant) : '0;
    assign grant_data = in_data[grant*WIDTH +: WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_sel   <= grant;
            ptr       <= grant + 3'd1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_mux_8to1.sv
// Directed bench for rr_mux_8to1: reset, priority rotation, wrap, backpressure
// and idle-hold scenarios with hand-computed expected values.
module tb_rr_mux_8to1;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_valid;
    logic [63:0] in_data;
    logic [7:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [2:0]  out_sel;
    logic        out_ready;

    int unsigned tests  = 0;
    int unsigned failed = 0;

    rr_mux_8to1 #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [2:0] s, input logic [7:0] d);
        check({tag, ".valid"}, 32'(out_valid), 32'(v));
        check({tag, ".sel"},   32'(out_sel),   32'(s));
        check({tag, ".data"},  32'(out_data),  32'(d));
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 8'hFF;
        in_data   = '0;
        out_ready = 1'b0;
        #2;
        check("rst.in_ready", 32'(in_ready), 32'h00);
        check_out("rst", 1'b0, 3'd0, 8'h00);
        check("rst.ptr", 32'(dut.ptr), 32'd0);
        cyc();
        cyc();
        in_valid = '0;
        rst      = 1'b0;

        // Reset mid-stream while a word is held under backpressure
        in_data[3*8 +: 8] = 8'h33;
        in_valid = 8'h08;
        #1;
        check("mid.in_ready", 32'(in_ready), 32'h08);
        cyc();
        in_valid = '0;
        check_out("mid.load", 1'b1, 3'd3, 8'h33);
        cyc();
        check_out("mid.hold", 1'b1, 3'd3, 8'h33);
        rst = 1'b1;
        #1;
        check_out("mid.async", 1'b0, 3'd0, 8'h00);
        cyc();
        rst       = 1'b0;
        out_ready = 1'b1;
        cyc();
        check("mid.gone1", 32'(out_valid), 32'd0);
        cyc();
        check("mid.gone2", 32'(out_valid), 32'd0);
        check("mid.ptr", 32'(dut.ptr), 32'd0);

        // Single lane 5
        in_data[5*8 +: 8] = 8'hA5;
        in_valid = 8'h20;
        #1;
        check("one.in_ready", 32'(in_ready), 32'h20);
        cyc();
        in_valid = '0;
        check_out("one.out", 1'b1, 3'd5, 8'hA5);
        check("one.ptr", 32'(dut.ptr), 32'd6);
        cyc();
        check("one.drain", 32'(out_valid), 32'd0);

        // All lanes valid from ptr=0: 0..7,0 back to back
        rst = 1'b1;
        #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = 8'(8'h10 + i);
        in_valid = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            cyc();
            check_out($sformatf("all%0d", k), 1'b1, 3'(k % 8), 8'(8'h10 + k % 8));
        end
        in_valid = '0;
        cyc();
        check("all.drain", 32'(out_valid), 32'd0);

        // Wrap priority: reach ptr=6 via lane 5, then lanes 1 and 7
        in_valid = 8'h20;
        cyc();
        in_valid = '0;
        check("wrap.ptr6", 32'(dut.ptr), 32'd6);
        in_valid = 8'h82;
        #1;
        check("wrap.rdy7", 32'(in_ready), 32'h80);
        cyc();
        check_out("wrap.g7", 1'b1, 3'd7, 8'h17);
        in_valid = 8'h02;
        #1;
        check("wrap.rdy1", 32'(in_ready), 32'h02);
        cyc();
        check_out("wrap.g1", 1'b1, 3'd1, 8'h11);
        check("wrap.ptr2", 32'(dut.ptr), 32'd2);
        in_valid = '0;
        cyc();

        // Backpressure: hold lane 6 word, lanes 2/3 wait, then no-bubble reload
        out_ready = 1'b0;
        in_valid  = 8'h40;
        cyc();
        check_out("bp.load", 1'b1, 3'd6, 8'h16);
        in_valid = 8'h0C;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("bp.rdy%0d", k), 32'(in_ready), 32'h00);
            cyc();
            check_out($sformatf("bp.hold%0d", k), 1'b1, 3'd6, 8'h16);
        end
        out_ready = 1'b1;
        #1;
        check("bp.rdy2", 32'(in_ready), 32'h04);
        cyc();
        check_out("bp.g2", 1'b1, 3'd2, 8'h12);
        in_valid = 8'h08;
        #1;
        check("bp.rdy3", 32'(in_ready), 32'h08);
        cyc();
        check_out("bp.g3", 1'b1, 3'd3, 8'h13);
        check("bp.ptr", 32'(dut.ptr), 32'd4);
        in_valid = '0;
        cyc();

        // Idle hold after lane 4
        in_valid = 8'h10;
        cyc();
        check_out("idle.g4", 1'b1, 3'd4, 8'h14);
        in_valid = '0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            check($sformatf("idle.v%0d", k), 32'(out_valid), 32'd0);
            check($sformatf("idle.ptr%0d", k), 32'(dut.ptr), 32'd5);
        end
        in_valid = 8'h21;
        #1;
        check("idle.rdy", 32'(in_ready), 32'h20);
        cyc();
        check_out("idle.g5", 1'b1, 3'd5, 8'h15);
        in_valid = 8'h01;
        cyc();
        check_out("idle.g0", 1'b1, 3'd0, 8'h10);
        in_valid = '0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
